// File: rtl/cmos_dvp_pattern_tx_pkg.sv
// Shared definitions for the DVP test-pattern transmitter: FSM states, pattern codes and pixel constants.
// Optional PRBS mode 3 is selected with CMOS_TX_PRBS_EN; its seed and taps live here.
package cmos_dvp_pattern_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_V_BACK  = 3'd1,
      ST_ACTIVE  = 3'd2,
      ST_V_FRONT = 3'd3,
      ST_VSYNC   = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      PAT_XRAMP = 2'd0,
      PAT_YRAMP = 2'd1,
      PAT_BARS  = 2'd2,
      PAT_MODE3 = 2'd3
   } pat_t;

   localparam logic [7:0] BAR_TOP   = 8'hFF;
   localparam logic [7:0] BAR_STEP  = 8'h24;
   localparam logic [7:0] PRBS_SEED = 8'hFF;
   // Feedback taps for the left-shifting PRBS8 (bits 7,4,3,0).
   localparam logic [7:0] PRBS_TAPS = 8'h99;

   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/cmos_tx_pattern_gen.sv
// RAW8 pattern generator: one register stage from (x, y, pattern, pix_en) to pixel; zero outside pix_en.
// CMOS_TX_PRBS_EN turns mode 3 into a PRBS8 stream, otherwise mode 3 is x + frame_cnt.
module cmos_tx_pattern_gen
   import cmos_dvp_pattern_tx_pkg::*;
#(
   parameter int H_ACTIVE = 640,
   parameter int XW       = 10
) (
   input  logic          cmos_pclk,
   input  logic          rst_n,
   input  logic          pix_en,
   input  logic [XW-1:0] x,
   input  logic [7:0]    y,
   input  pat_t          pattern,
`ifdef CMOS_TX_PRBS_EN
   input  logic          frame_start,
`else
   input  logic [7:0]    frame_cnt,
`endif
   output logic [7:0]    pix_dat
);

   localparam int BAR_W = H_ACTIVE / 8;

   logic [2:0] bar;
   logic [7:0] pix_d, pix_q;

   // Pixels past the last full bar (or every pixel when H_ACTIVE < 8) fall into bar 7.
   always_comb begin
      bar = 3'd0;
      for (int b = 1; b < 8; b++) begin
         if (32'(x) >= b * BAR_W) bar = 3'(b);
      end
   end

`ifdef CMOS_TX_PRBS_EN
   logic [7:0] lfsr_d, lfsr_q;

   always_comb begin
      lfsr_d = lfsr_q;
      if (frame_start)
         lfsr_d = PRBS_SEED;
      else if (pix_en && pattern == PAT_MODE3)
         lfsr_d = {lfsr_q[6:0], ^(lfsr_q & PRBS_TAPS)};
   end

   always_ff @(posedge cmos_pclk or negedge rst_n) begin
      if (!rst_n) lfsr_q <= PRBS_SEED;
      else        lfsr_q <= lfsr_d;
   end
`endif

   always_comb begin
      pix_d = 8'd0;
      if (pix_en) begin
         case (pattern)
            PAT_XRAMP: pix_d = 8'(x);
            PAT_YRAMP: pix_d = y;
            PAT_BARS:  pix_d = BAR_TOP - 8'(bar) * BAR_STEP;
`ifdef CMOS_TX_PRBS_EN
            PAT_MODE3: pix_d = lfsr_q;
`else
            PAT_MODE3: pix_d = 8'(x) + frame_cnt;
`endif
            default:   pix_d = 8'd0;
         endcase
      end
   end

   always_ff @(posedge cmos_pclk or negedge rst_n) begin
      if (!rst_n) pix_q <= 8'd0;
      else        pix_q <= pix_d;
   end

   assign pix_dat = pix_q;

endmodule

// File: rtl/cmos_dvp_pattern_tx.sv
// DVP sensor emulator: vsync/href timing FSM with h/v counters, frame counter and RAW8 patterns; all outputs registered.
// CMOS_TX_PRBS_EN selects PRBS8 for mode 3 instead of the moving ramp.
module cmos_dvp_pattern_tx
   import cmos_dvp_pattern_tx_pkg::*;
#(
   parameter int H_ACTIVE = 640,
   parameter int H_BLANK  = 160,
   parameter int V_ACTIVE = 480,
   parameter int V_BACK   = 2,
   parameter int V_FRONT  = 2,
   parameter int V_SYNC   = 3
) (
   input  logic       cmos_pclk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic [1:0] pattern_sel,
   output logic       cmos_vsync,
   output logic       cmos_href,
   output logic [7:0] cmos_data,
   output logic       frame_done,
   output logic [7:0] frame_cnt
);

   localparam int H_TOTAL = H_ACTIVE + H_BLANK;
   localparam int HW      = clog2_min1(H_TOTAL);
   localparam int V_MAX_A = (V_ACTIVE > V_BACK) ? V_ACTIVE : V_BACK;
   localparam int V_MAX_B = (V_FRONT > V_SYNC) ? V_FRONT : V_SYNC;
   localparam int V_MAX   = (V_MAX_A > V_MAX_B) ? V_MAX_A : V_MAX_B;
   localparam int VW      = clog2_min1(V_MAX);
   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);

   state_t        state_d, state_q;
   logic [HW-1:0] h_cnt_d, h_cnt_q;
   logic [VW-1:0] v_cnt_d, v_cnt_q, v_last;
   pat_t          pat_d, pat_q;
   logic          vsync_d, vsync_q, href_d, href_q, done_d, done_q;
   logic [7:0]    fcnt_d, fcnt_q;
   logic          frame_start;

   always_comb begin
      state_d = state_q;
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      case (state_q)
         ST_V_BACK:  v_last = VW'(V_BACK - 1);
         ST_ACTIVE:  v_last = VW'(V_ACTIVE - 1);
         ST_V_FRONT: v_last = VW'(V_FRONT - 1);
         ST_VSYNC:   v_last = VW'(V_SYNC - 1);
         default:    v_last = '0;
      endcase
      if (state_q == ST_IDLE) begin
         h_cnt_d = '0;
         v_cnt_d = '0;
         if (enable) state_d = ST_V_BACK;
      end else if (h_cnt_q != H_LAST) begin
         h_cnt_d = h_cnt_q + 1'b1;
      end else begin
         h_cnt_d = '0;
         if (v_cnt_q != v_last) begin
            v_cnt_d = v_cnt_q + 1'b1;
         end else begin
            v_cnt_d = '0;
            case (state_q)
               ST_V_BACK:  state_d = ST_ACTIVE;
               ST_ACTIVE:  state_d = ST_V_FRONT;
               ST_V_FRONT: state_d = ST_VSYNC;
               // enable only matters here, so a mid-frame drop still finishes the frame.
               ST_VSYNC:   state_d = enable ? ST_V_BACK : ST_IDLE;
               default:    state_d = ST_IDLE;
            endcase
         end
      end
   end

   // Outputs are decoded from next-state values so the registered copies line up with the state.
   always_comb begin
      frame_start = (state_d == ST_V_BACK) && (state_q != ST_V_BACK);
      vsync_d     = (state_d == ST_V_BACK) || (state_d == ST_ACTIVE) || (state_d == ST_V_FRONT);
      href_d      = (state_d == ST_ACTIVE) && (32'(h_cnt_d) < H_ACTIVE);
      done_d      = (state_d == ST_VSYNC) && (state_q != ST_VSYNC);
      fcnt_d      = done_d ? fcnt_q + 8'd1 : fcnt_q;
      pat_d       = frame_start ? pat_t'(pattern_sel) : pat_q;
   end

   always_ff @(posedge cmos_pclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         h_cnt_q <= '0;
         v_cnt_q <= '0;
         pat_q   <= PAT_XRAMP;
         vsync_q <= 1'b0;
         href_q  <= 1'b0;
         done_q  <= 1'b0;
         fcnt_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
         pat_q   <= pat_d;
         vsync_q <= vsync_d;
         href_q  <= href_d;
         done_q  <= done_d;
         fcnt_q  <= fcnt_d;
      end
   end

   cmos_tx_pattern_gen #(
      .H_ACTIVE (H_ACTIVE),
      .XW       (HW)
   ) u_pattern_gen (
      .cmos_pclk   (cmos_pclk),
      .rst_n       (rst_n),
      .pix_en      (href_d),
      .x           (h_cnt_d),
      .y           (8'(v_cnt_d)),
      .pattern     (pat_q),
`ifdef CMOS_TX_PRBS_EN
      .frame_start (frame_start),
`else
      .frame_cnt   (fcnt_q),
`endif
      .pix_dat     (cmos_data)
   );

   assign cmos_vsync = vsync_q;
   assign cmos_href  = href_q;
   assign frame_done = done_q;
   assign frame_cnt  = fcnt_q;

endmodule

// File: tb/tb_cmos_dvp_pattern_tx.sv
// Bench for cmos_dvp_pattern_tx with a small frame (8x4 active, 84-clock frame); pixel scoreboard plus timing checks.
module tb_cmos_dvp_pattern_tx;

   localparam int HA = 8;
   localparam int HB = 4;
   localparam int VA = 4;
   localparam int VB = 1;
   localparam int VF = 1;
   localparam int VS = 1;
   localparam int HT = HA + HB;

   logic       cmos_pclk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic [1:0] pattern_sel;
   logic       cmos_vsync, cmos_href, frame_done;
   logic [7:0] cmos_data, frame_cnt;

   int checks   = 0;
   int errors   = 0;
   int cyc      = 0;
   int href_cnt = 0;
   int done_cnt = 0;
   int rise_cyc = 0;
   int h0       = 0;
   logic [7:0] sb_q[$];

   cmos_dvp_pattern_tx #(
      .H_ACTIVE (HA),
      .H_BLANK  (HB),
      .V_ACTIVE (VA),
      .V_BACK   (VB),
      .V_FRONT  (VF),
      .V_SYNC   (VS)
   ) dut (
      .cmos_pclk   (cmos_pclk),
      .rst_n       (rst_n),
      .enable      (enable),
      .pattern_sel (pattern_sel),
      .cmos_vsync  (cmos_vsync),
      .cmos_href   (cmos_href),
      .cmos_data   (cmos_data),
      .frame_done  (frame_done),
      .frame_cnt   (frame_cnt)
   );

   always #5 cmos_pclk = ~cmos_pclk;
   always @(posedge cmos_pclk) cyc++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", tag, obs, obs, exp, exp, cyc);
      end
   endtask

   // Expected pixels for one whole frame, in raster order.
   task automatic push_frame(input int sel, input int fc);
      logic [7:0] lf;
      logic [7:0] e;
      int         bar;
      lf = 8'hFF;
      for (int y = 0; y < VA; y++) begin
         for (int x = 0; x < HA; x++) begin
            case (sel)
               0: e = 8'(x);
               1: e = 8'(y);
               2: begin
                  bar = (HA / 8 == 0) ? 7 : x / (HA / 8);
                  if (bar > 7) bar = 7;
                  e = 8'(255 - bar * 36);
               end
               default: begin
`ifdef CMOS_TX_PRBS_EN
                  e  = lf;
                  lf = {lf[6:0], lf[7] ^ lf[4] ^ lf[3] ^ lf[0]};
`else
                  e = 8'(x + fc);
`endif
               end
            endcase
            sb_q.push_back(e);
         end
      end
   endtask

   task automatic wait_vsync(input logic lvl, input int budget);
      int n = 0;
      while (cmos_vsync !== lvl && n < budget) begin
         @(negedge cmos_pclk);
         n++;
      end
      if (cmos_vsync !== lvl) check("timeout_vsync", 32'(cmos_vsync), 32'(lvl));
   endtask

   task automatic wait_href(input int budget);
      int n = 0;
      while (cmos_href !== 1'b1 && n < budget) begin
         @(negedge cmos_pclk);
         n++;
      end
      if (cmos_href !== 1'b1) check("timeout_href", 32'(cmos_href), 1);
   endtask

   // Scoreboard side: every href-high sample pops one expected pixel.
   always @(negedge cmos_pclk) begin
      if (cmos_href === 1'b1) begin
         href_cnt++;
         if (sb_q.size() == 0) check("sb_underflow", 1, 0);
         else                  check("pixel", 32'(cmos_data), 32'(sb_q.pop_front()));
      end else begin
         check("data_blank", 32'(cmos_data), 0);
      end
      if (frame_done === 1'b1) done_cnt++;
   end

   // Waits for the end of the running frame and checks its timing and pixel count.
   task automatic finish_frame(input string tag, input int exp_fcnt);
      wait_vsync(1'b0, 200);
      check({tag, "_vsync_high"}, 32'(cyc - rise_cyc), (VB + VA + VF) * HT);
      check({tag, "_done_at_fall"}, 32'(frame_done), 1);
      check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_fcnt));
      check({tag, "_href_count"}, 32'(href_cnt - h0), HA * VA);
      @(negedge cmos_pclk);
      check({tag, "_done_width"}, 32'(frame_done), 0);
   endtask

   task automatic next_rise(input string tag);
      wait_vsync(1'b1, 200);
      check({tag, "_period"}, 32'(cyc - rise_cyc), (VB + VA + VF + VS) * HT);
      rise_cyc = cyc;
      h0       = href_cnt;
   endtask

   initial begin
      int hd;
      rst_n       = 1'b0;
      enable      = 1'b0;
      pattern_sel = 2'd0;
      repeat (3) @(negedge cmos_pclk);
      check("rst_vsync", 32'(cmos_vsync), 0);
      check("rst_href", 32'(cmos_href), 0);
      check("rst_data", 32'(cmos_data), 0);
      check("rst_done", 32'(frame_done), 0);
      check("rst_frame_cnt", 32'(frame_cnt), 0);
      rst_n = 1'b1;

      repeat (50) begin
         @(negedge cmos_pclk);
         check("idle_vsync", 32'(cmos_vsync), 0);
         check("idle_href", 32'(cmos_href), 0);
      end
      check("idle_done_cnt", 32'(done_cnt), 0);
      check("idle_frame_cnt", 32'(frame_cnt), 0);

      // Frame 1: x ramp; sel changed mid-frame must not disturb it.
      enable = 1'b1;
      @(negedge cmos_pclk);
      check("f1_rise_latency", 32'(cmos_vsync), 1);
      rise_cyc = cyc;
      h0       = href_cnt;
      push_frame(0, 0);
      wait_href(100);
      hd = cyc - rise_cyc;
      check("f1_href_delay", 32'(hd), VB * HT);
      pattern_sel = 2'd2;
      finish_frame("f1", 1);

      // Frame 2: colour bars; sel flipped to y ramp mid-frame.
      next_rise("f2");
      push_frame(2, 1);
      repeat (20) @(negedge cmos_pclk);
      pattern_sel = 2'd1;
      finish_frame("f2", 2);

      // Frame 3: y ramp.
      next_rise("f3");
      push_frame(1, 2);
      pattern_sel = 2'd3;
      finish_frame("f3", 3);

      // Frame 4: mode 3, enable dropped during ACTIVE.
      next_rise("f4");
      push_frame(3, 3);
      repeat (20) @(negedge cmos_pclk);
      enable = 1'b0;
      finish_frame("f4", 4);
      repeat (120) begin
         @(negedge cmos_pclk);
         check("stopped_vsync", 32'(cmos_vsync), 0);
      end
      check("stopped_done_cnt", 32'(done_cnt), 4);
      check("stopped_frame_cnt", 32'(frame_cnt), 4);
      check("stopped_sb_empty", 32'(sb_q.size()), 0);

      // Asynchronous reset in the middle of ACTIVE.
      pattern_sel = 2'd0;
      enable      = 1'b1;
      @(negedge cmos_pclk);
      check("f5_rise_latency", 32'(cmos_vsync), 1);
      push_frame(0, 4);
      repeat (15) @(negedge cmos_pclk);
      check("f5_href_before_rst", 32'(cmos_href), 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_vsync", 32'(cmos_vsync), 0);
      check("arst_href", 32'(cmos_href), 0);
      check("arst_data", 32'(cmos_data), 0);
      check("arst_frame_cnt", 32'(frame_cnt), 0);
      sb_q.delete();
      @(negedge cmos_pclk);
      rst_n = 1'b1;
      @(negedge cmos_pclk);
      check("f6_rise_after_rst", 32'(cmos_vsync), 1);
      rise_cyc = cyc;
      h0       = href_cnt;
      push_frame(0, 0);
      enable = 1'b0;
      finish_frame("f6", 1);
      repeat (30) @(negedge cmos_pclk);
      check("end_vsync", 32'(cmos_vsync), 0);
      check("end_done_cnt", 32'(done_cnt), 5);
      check("end_sb_empty", 32'(sb_q.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
